// File: rtl/demux4_buffered_if.sv
// Producer/consumer bundle for the buffered 1:4 demux.
// The producer side feeds in_*, each consumer channel drains out_*.
interface demux4_buffered_if #(
    parameter int dataSize = 16
);
    logic [dataSize-1:0] in_data;
    logic                in_valid;
    logic [1:0]          selector;
    logic                in_ready;
    logic [dataSize-1:0] out_data0;
    logic [dataSize-1:0] out_data1;
    logic [dataSize-1:0] out_data2;
    logic [dataSize-1:0] out_data3;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic [7:0]          occupancy;

    modport master (
        output in_data, in_valid, selector, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3,
        input  out_valid, occupancy
    );

    modport slave (
        input  in_data, in_valid, selector, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3,
        output out_valid, occupancy
    );
endinterface

// File: rtl/demux4_buffered.sv
// 1:4 stream demux with an independent 2-entry FIFO per channel.
// Registered outputs only; no input-to-output combinational data path.
module demux4_buffered #(
    parameter int dataSize = 16
) (
    input logic clk,
    input logic rst_n,
    demux4_buffered_if.slave bus
);
    logic [dataSize-1:0] mem_q [4][2];
    logic [1:0]          cnt_q [4];
    logic [1:0]          cnt_d [4];
    logic                rd_q  [4];
    logic                rd_d  [4];
    logic                wr_q  [4];
    logic                wr_d  [4];
    logic [dataSize-1:0] head  [4];
    logic [3:0]          push;
    logic [3:0]          pop;
    logic [3:0]          vld;
    logic                rdy;

    // Ready looks only at the targeted channel's count, never at in_valid.
    assign rdy = (cnt_q[bus.selector] != 2'd2);

    always_comb begin
        vld  = '0;
        push = '0;
        pop  = '0;
        for (int i = 0; i < 4; i++) begin
            vld[i]  = (cnt_q[i] != 2'd0);
            head[i] = vld[i] ? mem_q[i][rd_q[i]] : '0;
            push[i] = bus.in_valid && rdy && (bus.selector == 2'(i));
            pop[i]  = vld[i] && bus.out_ready[i];
            cnt_d[i] = cnt_q[i];
            rd_d[i]  = rd_q[i];
            wr_d[i]  = wr_q[i];
            if (push[i]) wr_d[i] = ~wr_q[i];
            if (pop[i])  rd_d[i] = ~rd_q[i];
            unique case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]    <= 2'd0;
                rd_q[i]     <= 1'b0;
                wr_q[i]     <= 1'b0;
                mem_q[i][0] <= '0;
                mem_q[i][1] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
                rd_q[i]  <= rd_d[i];
                wr_q[i]  <= wr_d[i];
                if (push[i]) mem_q[i][wr_q[i]] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_data0 = head[0];
    assign bus.out_data1 = head[1];
    assign bus.out_data2 = head[2];
    assign bus.out_data3 = head[3];
    assign bus.occupancy = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
endmodule
